// File: rtl/mic_frame_buffer_if.sv
// Stream bundle between the mic capture side, the frame buffer and the FFT.
// The slave modport is the frame buffer itself.
// The master modport is whatever feeds samples in and consumes frames out.
`timescale 1ns/1ps

interface mic_frame_buffer_if #(
   parameter int DATA_W = 12
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_first;
   logic              out_last;
   logic              overflow;
   logic              overflow_clr;

   modport master (
      output in_valid, in_data, out_ready, overflow_clr,
      input  out_valid, out_data, out_first, out_last, overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready, overflow_clr,
      output out_valid, out_data, out_first, out_last, overflow
   );
endinterface

// File: rtl/mic_frame_buffer.sv
// Ping-pong frame buffer between the Pmod MIC receiver and the FFT core.
// Each mic sample is re-centred around zero as it is captured.
// Samples are gathered into FRAME_LEN-word frames, alternating between two banks.
// Every full bank is streamed out as one contiguous valid/ready burst with first/last markers.
// The read side only ever opens a bank once it is completely full, so partial frames never leave.
`timescale 1ns/1ps

module mic_frame_buffer #(
   parameter int DATA_W    = 12,
   parameter int FRAME_LEN = 64,
   parameter int ADDR_W    = 6,
   parameter int DC_OFFSET = 2048
) (
   input logic                clk,
   input logic                rst,
   mic_frame_buffer_if.slave  bus
);

   localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FRAME_LEN - 1);
   localparam logic [DATA_W-1:0] DC_CODE  = DATA_W'(DC_OFFSET);

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_STREAM = 2'd1,
      RD_DRAIN  = 2'd2
   } rd_state_t;

   // Bank b occupies words b*FRAME_LEN .. b*FRAME_LEN+FRAME_LEN-1, addressed as {bank, ptr}.
   logic [DATA_W-1:0] mem_r [0:2*FRAME_LEN-1];

   logic [ADDR_W-1:0] wr_ptr_r;
   logic              wr_bank_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic              rd_bank_r;
   logic [1:0]        bank_full_r;
   rd_state_t         rd_state_r;

   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic              out_first_r;
   logic              out_last_r;
   logic              overflow_r;

   logic              rd_free_s;
   logic              wr_blocked_s;
   logic              wr_en_s;
   logic              drop_s;
   logic              wr_done_s;
   logic [ADDR_W-1:0] rd_ptr_nxt_s;
   logic [DATA_W-1:0] sample_s;
   logic [1:0]        bank_full_nxt_s;

   // Write/read side control decode, including the same-cycle free-and-write bypass.
   always_comb begin
      rd_free_s       = 1'b0;
      wr_blocked_s    = 1'b0;
      bank_full_nxt_s = bank_full_r;
      if ((rd_state_r == RD_STREAM) && bus.out_ready && (rd_ptr_r == PTR_LAST)) begin
         rd_free_s = 1'b1;
      end else begin
         rd_free_s = 1'b0;
      end
      // A bank released this very cycle is already writable.
      wr_blocked_s = bank_full_r[wr_bank_r] && !(rd_free_s && (rd_bank_r == wr_bank_r));
      wr_en_s      = bus.in_valid && !wr_blocked_s;
      drop_s       = bus.in_valid && wr_blocked_s;
      wr_done_s    = wr_en_s && (wr_ptr_r == PTR_LAST);
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      // Modulo subtraction; with mid-scale offset this just flips the MSB.
      sample_s     = bus.in_data - DC_CODE;
      for (int b = 0; b < 2; b++) begin
         if (wr_done_s && (wr_bank_r == 1'(b))) begin
            bank_full_nxt_s[b] = 1'b1;
         end else if (rd_free_s && (rd_bank_r == 1'(b))) begin
            bank_full_nxt_s[b] = 1'b0;
         end else begin
            bank_full_nxt_s[b] = bank_full_r[b];
         end
      end
   end

   // Sample storage; contents need no reset since the flags gate every read.
   always_ff @(posedge clk) begin
      if (!rst && wr_en_s) begin
         mem_r[{wr_bank_r, wr_ptr_r}] <= sample_s;
      end
   end

   // Write pointer and bank selection; a full target bank leaves them frozen at index 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r  <= PTR_ZERO;
         wr_bank_r <= 1'b0;
      end else if (wr_done_s) begin
         wr_ptr_r  <= PTR_ZERO;
         wr_bank_r <= ~wr_bank_r;
      end else if (wr_en_s) begin
         wr_ptr_r  <= wr_ptr_r + PTR_ONE;
      end
   end

   // Bank ownership flags: set by the writer on frame completion, cleared by the reader after its last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_full_r <= 2'b00;
      end else begin
         bank_full_r <= bank_full_nxt_s;
      end
   end

   // Sticky overflow; a clear wins over a drop in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (bus.overflow_clr) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end
   end

   // Read FSM with registered stream outputs; beats hold while the FFT stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_r  <= RD_IDLE;
         rd_ptr_r    <= PTR_ZERO;
         rd_bank_r   <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_first_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         case (rd_state_r)
            RD_IDLE: begin
               if (bank_full_r[rd_bank_r]) begin
                  rd_state_r  <= RD_STREAM;
                  rd_ptr_r    <= PTR_ZERO;
                  out_valid_r <= 1'b1;
                  out_data_r  <= mem_r[{rd_bank_r, PTR_ZERO}];
                  out_first_r <= 1'b1;
                  out_last_r  <= 1'b0;
               end else begin
                  out_valid_r <= 1'b0;
               end
            end
            RD_STREAM: begin
               if (bus.out_ready) begin
                  if (rd_ptr_r == PTR_LAST) begin
                     rd_state_r  <= RD_DRAIN;
                     rd_ptr_r    <= PTR_ZERO;
                     rd_bank_r   <= ~rd_bank_r;
                     out_valid_r <= 1'b0;
                     out_first_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     rd_ptr_r    <= rd_ptr_nxt_s;
                     out_data_r  <= mem_r[{rd_bank_r, rd_ptr_nxt_s}];
                     out_first_r <= 1'b0;
                     out_last_r  <= (rd_ptr_nxt_s == PTR_LAST);
                  end
               end
            end
            RD_DRAIN: begin
               // Forced idle cycle between frames.
               rd_state_r  <= RD_IDLE;
               out_valid_r <= 1'b0;
            end
            default: begin
               rd_state_r  <= RD_IDLE;
               out_valid_r <= 1'b0;
               out_first_r <= 1'b0;
               out_last_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_first = out_first_r;
   assign bus.out_last  = out_last_r;
   assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Self-checking bench for mic_frame_buffer: accepted samples are queued with
// their expected signed value and frame markers, and each output handshake
// pops and compares one entry. Stall stability and inter-frame gaps are checked
// on every cycle.
`timescale 1ns/1ps

module tb_mic_frame_buffer;

   localparam int DATA_W    = 12;
   localparam int FRAME_LEN = 64;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              first;
      logic              last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mic_frame_buffer_if #(.DATA_W(DATA_W)) bus ();

   mic_frame_buffer #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN),
      .ADDR_W    (6),
      .DC_OFFSET (2048)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t             sb_q[$];
   beat_t             mon_b;
   int                vec_cnt    = 0;
   int                err_cnt    = 0;
   int                hs_cnt     = 0;
   int                acc_cnt    = 0;
   int                ready_mode = 1;
   int                cyc        = 0;
   int                h0;
   logic              prev_stall = 1'b0;
   logic              prev_last  = 1'b0;
   logic [DATA_W-1:0] held_d;
   logic              held_f;
   logic              held_l;

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // out_ready driver: 0 = held low, 1 = held high, 2 = high one cycle in three.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      case (ready_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = ((cyc % 3) == 0);
      endcase
   end

   // Output monitor: scoreboard compare on handshakes, stability while stalled, gap after a frame.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_last  = 1'b0;
      end else begin
         if (prev_stall) begin
            check_val("stall_valid", 32'(bus.out_valid), 32'd1);
            check_val("stall_data",  32'(bus.out_data),  32'(held_d));
            check_val("stall_first", 32'(bus.out_first), 32'(held_f));
            check_val("stall_last",  32'(bus.out_last),  32'(held_l));
         end
         if (prev_last) begin
            check_val("frame_gap", 32'(bus.out_valid), 32'd0);
         end
         if (bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
               check_val("beat_expected", 32'(sb_q.size()), 32'd1);
            end else begin
               mon_b = sb_q.pop_front();
               check_val("out_data",  32'(bus.out_data),  32'(mon_b.data));
               check_val("out_first", 32'(bus.out_first), 32'(mon_b.first));
               check_val("out_last",  32'(bus.out_last),  32'(mon_b.last));
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_last  = bus.out_valid && bus.out_ready && bus.out_last;
         held_d     = bus.out_data;
         held_f     = bus.out_first;
         held_l     = bus.out_last;
      end
   end

   // One strobe followed by one quiet cycle plus 'idle' extra cycles.
   task automatic send(input logic [DATA_W-1:0] v, input bit dropped, input int idle);
      beat_t b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      if (!dropped) begin
         b.data  = {~v[DATA_W-1], v[DATA_W-2:0]};
         b.first = (acc_cnt == 0);
         b.last  = (acc_cnt == FRAME_LEN - 1);
         sb_q.push_back(b);
         acc_cnt = (acc_cnt + 1) % FRAME_LEN;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (idle) @(posedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_val("drain", 32'(sb_q.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_valid"},    32'(bus.out_valid), 32'd0);
      check_val({tag, "_first"},    32'(bus.out_first), 32'd0);
      check_val({tag, "_last"},     32'(bus.out_last),  32'd0);
      check_val({tag, "_data"},     32'(bus.out_data),  32'd0);
      check_val({tag, "_overflow"}, 32'(bus.overflow),  32'd0);
   endtask

   // Global time bound.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Test sequence.
   initial begin
      bus.in_valid     = 1'b0;
      bus.in_data      = '0;
      bus.overflow_clr = 1'b0;
      rst              = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("reset");

      // 1: ramp 0..63 -> -2048..-1985
      h0 = hs_cnt;
      for (int i = 0; i < FRAME_LEN; i++) send(12'(i), 1'b0, 0);
      wait_drain(300);
      check_val("t1_beats", 32'(hs_cnt - h0), 32'd64);
      check_val("t1_overflow", 32'(bus.overflow), 32'd0);

      // 2: offset corner codes
      send(12'd2048, 1'b0, 0);
      send(12'd4095, 1'b0, 0);
      send(12'd0,    1'b0, 0);
      for (int i = 3; i < FRAME_LEN; i++) send(12'((i * 50) % 4096), 1'b0, 0);
      wait_drain(300);

      // 3: one-in-three ready during a frame
      h0 = hs_cnt;
      ready_mode = 2;
      for (int i = 0; i < FRAME_LEN; i++) send(12'((i * 37 + 5) % 4096), 1'b0, 0);
      wait_drain(800);
      ready_mode = 1;
      check_val("t3_beats", 32'(hs_cnt - h0), 32'd64);

      // 4: FFT stalled, both banks fill, then overflow
      ready_mode = 0;
      repeat (2) @(posedge clk);
      h0 = hs_cnt;
      for (int i = 0; i < 200; i++) begin
         send(12'(i), (i >= 128), 0);
         if (i == 127) check_val("t4_ovf_before", 32'(bus.overflow), 32'd0);
         if (i == 128) check_val("t4_ovf_set", 32'(bus.overflow), 32'd1);
      end
      check_val("t4_no_beats_stalled", 32'(hs_cnt - h0), 32'd0);
      ready_mode = 1;
      wait_drain(600);
      check_val("t4_beats", 32'(hs_cnt - h0), 32'd128);
      check_val("t4_ovf_sticky", 32'(bus.overflow), 32'd1);
      @(posedge clk);
      #1;
      bus.overflow_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.overflow_clr = 1'b0;
      check_val("t4_ovf_clr", 32'(bus.overflow), 32'd0);

      // 5: reset after 40 samples discards the partial frame
      h0 = hs_cnt;
      for (int i = 0; i < 40; i++) send(12'(1000 + i), 1'b0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("t5_reset");
      sb_q.delete();
      acc_cnt = 0;
      repeat (80) @(posedge clk);
      check_val("t5_no_partial", 32'(hs_cnt - h0), 32'd0);
      for (int i = 0; i < FRAME_LEN; i++) send(12'((i * 61 + 7) % 4096), 1'b0, 0);
      wait_drain(300);
      check_val("t5_beats", 32'(hs_cnt - h0), 32'd64);

      // 6: strobe every 8 cycles, back-to-back frames
      h0 = hs_cnt;
      for (int i = 0; i < 3 * FRAME_LEN; i++) send(12'((i * 23 + 100) % 4096), 1'b0, 6);
      wait_drain(300);
      check_val("t6_beats", 32'(hs_cnt - h0), 32'd192);
      check_val("t6_overflow", 32'(bus.overflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
